// File: rtl/wb_slave_decoder.sv
// Wishbone classic address decoder: routes one upstream master to NSLV windowed
// slaves, answers decode misses and downstream timeouts with ERR_DATA.
module wb_slave_decoder #(
  parameter int          NSLV     = 4,
  parameter logic [31:0] BASE     = 32'h3000_0000,
  parameter int          WIN_BITS = 16,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [NSLV-1:0]    m_cyc_o,
  output logic [NSLV-1:0]    m_stb_o,
  output logic               m_we_o,
  output logic [3:0]         m_sel_o,
  output logic [31:0]        m_adr_o,
  output logic [31:0]        m_dat_o,
  input  logic [NSLV-1:0]    m_ack_i,
  input  logic [NSLV*32-1:0] m_dat_i,
  output logic               to_irq_o,
  output logic [7:0]         err_cnt_o
);

  localparam int DEC_BITS = $clog2(NSLV);
  localparam int IDX_W    = (NSLV > 1) ? DEC_BITS : 1;
  localparam int HI       = WIN_BITS + DEC_BITS;

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              m_en_q, m_en_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              irq_q, irq_d;
  logic [7:0]        err_q, err_d;

  logic              req;
  logic              tag_match;
  logic [31:0]       slot;
  logic              hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              slv_ack;
  logic [31:0]       slv_rdat;
  logic              timeout_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Address decode of the live upstream request
  always_comb begin
    req       = wbs_cyc_i && wbs_stb_i;
    tag_match = ((wbs_adr_i >> HI) == (BASE >> HI));
    slot      = (wbs_adr_i >> WIN_BITS) & ((32'd1 << DEC_BITS) - 32'd1);
    hit       = tag_match && (slot < 32'(NSLV));
    dec_idx   = slot[IDX_W-1:0];
  end

  // Only the selected slave's ack and data are ever looked at
  always_comb begin
    slv_ack     = m_ack_i[idx_q];
    slv_rdat    = m_dat_i[32*idx_q +: 32];
    timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = hit ? FWD : RESP;
      FWD: begin
        if (!wbs_cyc_i)                   state_d = IDLE;
        else if (slv_ack || timeout_hit)  state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    m_en_d = m_en_q;
    we_d   = we_q;
    sel_d  = sel_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    ack_d  = 1'b0;
    rdat_d = rdat_q;
    irq_d  = 1'b0;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d  = wbs_we_i;
          sel_d = wbs_sel_i;
          adr_d = wbs_adr_i;
          dat_d = wbs_dat_i;
          idx_d = dec_idx;
          cnt_d = 16'd0;
          if (hit) begin
            m_en_d = 1'b1;
          end else begin
            ack_d  = 1'b1;
            rdat_d = ERR_DATA;
            err_d  = sat_inc(err_q);
          end
        end
      end
      FWD: begin
        if (!wbs_cyc_i) begin
          m_en_d = 1'b0;
        end else if (slv_ack) begin
          // Ack beats a coincident timeout
          m_en_d = 1'b0;
          ack_d  = 1'b1;
          rdat_d = we_q ? 32'd0 : slv_rdat;
        end else if (timeout_hit) begin
          m_en_d = 1'b0;
          ack_d  = 1'b1;
          rdat_d = ERR_DATA;
          irq_d  = 1'b1;
          err_d  = sat_inc(err_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      m_en_q <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      rdat_q <= '0;
      irq_q  <= 1'b0;
      err_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      m_en_q <= m_en_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      ack_q  <= ack_d;
      rdat_q <= rdat_d;
      irq_q  <= irq_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    m_cyc_o = '0;
    for (int i = 0; i < NSLV; i++) m_cyc_o[i] = m_en_q && (idx_q == IDX_W'(i));
  end

  assign m_stb_o   = m_cyc_o;
  assign m_we_o    = we_q;
  assign m_sel_o   = sel_q;
  assign m_adr_o   = adr_q;
  assign m_dat_o   = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign to_irq_o  = irq_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Self-checking bench for wb_slave_decoder: directed vector table, hand-written
// abort/reset sequences and randomized transactions against a window-range model.
module tb_wb_slave_decoder;

  localparam int          NSLV = 3;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int          WIN  = 65536;
  localparam int          NEVER = 1000;

  logic               clk = 1'b0;
  logic               rst;
  logic               cyc, stb, we;
  logic [3:0]         sel;
  logic [31:0]        adr, wdat;
  logic               ack;
  logic [31:0]        rdat;
  logic [NSLV-1:0]    m_cyc, m_stb;
  logic               m_we;
  logic [3:0]         m_sel;
  logic [31:0]        m_adr, m_dat;
  logic [NSLV-1:0]    m_ack;
  logic [NSLV*32-1:0] m_rdat;
  logic               irq;
  logic [7:0]         err_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_err;

  wb_slave_decoder #(.NSLV(NSLV), .BASE(BASE), .WIN_BITS(16), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat),
    .m_ack_i(m_ack), .m_dat_i(m_rdat),
    .to_irq_o(irq), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] v, input int inc);
    int s;
    s = int'(v) + inc;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  // Non-selected acks and data are random noise; the selected slave gets sdat
  task automatic set_acks(input int slv, input logic bit_v, input logic [31:0] sdat);
    m_ack  = NSLV'($urandom);
    m_rdat = {$urandom, $urandom, $urandom};
    if (slv >= 0) begin
      m_ack[slv] = bit_v;
      m_rdat[slv*32 +: 32] = sdat;
    end
  endtask

  // Hit iff the address lies inside one of the NSLV windows above BASE
  task automatic model(input logic [31:0] a, input logic w, input int d, input logic [31:0] sdat,
                       output int lat, output logic [31:0] edat, output logic eirq,
                       output int slv, output int inc);
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(BASE);
    if (ua >= ub && ua < ub + longint'(NSLV) * WIN) begin
      slv = int'((ua - ub) / WIN);
      if (d <= TO - 1) begin
        lat = d + 2; edat = w ? 32'd0 : sdat; eirq = 1'b0; inc = 0;
      end else begin
        lat = TO + 1; edat = ERRD; eirq = 1'b1; inc = 1;
      end
    end else begin
      slv = -1; lat = 1; edat = ERRD; eirq = 1'b0; inc = 1;
    end
  endtask

  // Caller is just past a negedge; the request is sampled at the coming posedge (T)
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd, input int d,
                         input logic [31:0] sdat, input int lat, input logic [31:0] edat,
                         input logic eirq, input int slv, input int inc);
    logic [31:0] exp_stb;
    logic [3:0]  s;
    s = 4'($urandom);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = wd; sel = s;
    set_acks(slv, 1'b0, sdat);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      exp_stb = (slv >= 0 && k < lat) ? (32'd1 << slv) : 32'd0;
      chk("m_stb", 32'(m_stb), exp_stb);
      chk("m_cyc", 32'(m_cyc), exp_stb);
      chk("ack", 32'(ack), 32'(k == lat));
      chk("irq", 32'(irq), 32'((k == lat) && eirq));
      if (k == 1 && slv >= 0) begin
        chk("m_adr", m_adr, a);
        chk("m_we", 32'(m_we), 32'(w));
        chk("m_dat", m_dat, wd);
        chk("m_sel", 32'(m_sel), 32'(s));
      end
      if (k == lat) begin
        exp_err = sat(exp_err, inc);
        chk("rdata", rdat, edat);
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        cyc = 1'b0; stb = 1'b0;
      end
      if (k == lat + 1) chk("rdata_hold", rdat, edat);
      set_acks(slv, (slv >= 0) && (k - 1 == d) && (k < lat), sdat);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    int          d;
    logic [31:0] sdat;
    int          lat;
    logic [31:0] edat;
    logic        irq;
    int          slv;
    int          inc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat, slv, inc, d;
    logic [31:0] a, sd, ed;
    logic w, ei;

    tbl[0] = '{32'h3001_0010, 1'b0, 32'h0,         3,     32'h1234_5678, 5, 32'h1234_5678, 1'b0,  1, 0};
    tbl[1] = '{32'h3100_0000, 1'b0, 32'h0,         0,     32'h0,         1, ERRD,          1'b0, -1, 1};
    tbl[2] = '{32'h3002_0000, 1'b0, 32'h0,         NEVER, 32'h55AA_55AA, 9, ERRD,          1'b1,  2, 1};
    tbl[3] = '{32'h3002_0004, 1'b0, 32'h0,         7,     32'hCAFE_F00D, 9, 32'hCAFE_F00D, 1'b0,  2, 0};
    tbl[4] = '{32'h3003_0000, 1'b0, 32'h0,         0,     32'h0,         1, ERRD,          1'b0, -1, 1};
    tbl[5] = '{32'h3000_0004, 1'b1, 32'h1122_3344, 0,     32'h9999_9999, 2, 32'h0,         1'b0,  0, 0};
    tbl[6] = '{32'h3004_0000, 1'b1, 32'h0,         0,     32'h0,         1, ERRD,          1'b0, -1, 1};
    tbl[7] = '{32'h3000_FFFC, 1'b0, 32'h0,         1,     32'hA5A5_A5A5, 3, 32'hA5A5_A5A5, 1'b0,  0, 0};
    tbl[8] = '{32'h3002_0000, 1'b1, 32'h7777_7777, 8,     32'h0,         9, ERRD,          1'b1,  2, 1};
    tbl[9] = '{32'h3001_0000, 1'b0, 32'h0,         0,     32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b0,  1, 0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    m_ack = '0; m_rdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdat, 32'd0);
    chk("rst_m_cyc", 32'(m_cyc), 32'd0);
    chk("rst_m_stb", 32'(m_stb), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_sel", 32'(m_sel), 32'd0);
    chk("rst_m_adr", m_adr, 32'd0);
    chk("rst_m_dat", m_dat, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    exp_err = 8'd0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].adr, tbl[i].we, tbl[i].wdat, tbl[i].d, tbl[i].sdat,
              tbl[i].lat, tbl[i].edat, tbl[i].irq, tbl[i].slv, tbl[i].inc);

    // Master abandons the cycle during the second forward cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0000; wdat = '0;
    set_acks(1, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort_stb1", 32'(m_stb), 32'h2);
    set_acks(1, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort_stb2", 32'(m_stb), 32'h2);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_cyc_drop", 32'(m_cyc), 32'd0);
    for (int k = 0; k < 12; k++) begin
      chk("abort_no_ack", 32'(ack), 32'd0);
      chk("abort_no_irq", 32'(irq), 32'd0);
      @(negedge clk);
    end
    chk("abort_err_cnt", 32'(err_cnt), 32'(exp_err));
    run_txn(32'h3000_0004, 1'b1, 32'hFEED_0001, 0, 32'h1111_1111, 2, 32'h0, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 3)) * 32'(WIN) + ($urandom & 32'h0000_FFFC);
      endcase
      w  = 1'($urandom);
      d  = $urandom_range(0, 10);
      sd = $urandom;
      model(a, w, d, sd, lat, ed, ei, slv, inc);
      run_txn(a, w, $urandom, d, sd, lat, ed, ei, slv, inc);
    end

    // Reset lands while a slave is being waited on
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0040; wdat = 32'h5A5A_0000;
    set_acks(1, 1'b0, 32'h0);
    @(negedge clk);
    chk("rstfwd_stb", 32'(m_stb), 32'h2);
    set_acks(1, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstfwd_m_stb", 32'(m_stb), 32'd0);
    chk("rstfwd_m_cyc", 32'(m_cyc), 32'd0);
    chk("rstfwd_m_adr", m_adr, 32'd0);
    chk("rstfwd_m_dat", m_dat, 32'd0);
    chk("rstfwd_ack", 32'(ack), 32'd0);
    chk("rstfwd_rdata", rdat, 32'd0);
    chk("rstfwd_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    exp_err = 8'd0;
    for (int k = 0; k < 12; k++) begin
      set_acks(1, 1'b1, 32'h0);
      @(negedge clk);
      chk("rstfwd_no_ack", 32'(ack), 32'd0);
      chk("rstfwd_no_irq", 32'(irq), 32'd0);
    end

    for (int i = 0; i < 300; i++)
      run_txn(32'h4000_0000 + 32'(i * 4), 1'b0, 32'h0, 0, 32'h0, 1, ERRD, 1'b0, -1, 1);
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_slave_decoder.md
WB_SLAVE_DECODER -- requirements
Module: wb_slave_decoder

Interface
REQ-001 Parameter NSLV, default 4: number of downstream Wishbone slave ports, 1..16.
REQ-002 Parameter BASE, default 32'h3000_0000: user-area base address; only bits above the decoded window are compared.
REQ-003 Parameter WIN_BITS, default 16: address bits per slave window.
REQ-004 Parameter TIMEOUT, default 255: maximum number of downstream wait cycles, 2..65535.
REQ-005 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on a decode miss or a timeout.
REQ-006 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-007 wb_clk_i  in  1: the single clock; all state updates on its rising edge.
REQ-008 wb_rst_i  in  1: synchronous, active-high reset.
REQ-009 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each: upstream Wishbone classic controls.
REQ-010 wbs_sel_i  in  4; wbs_adr_i  in  32; wbs_dat_i  in  32: upstream byte select, address and write data.
REQ-011 wbs_ack_o  out  1; wbs_dat_o  out  32: upstream acknowledge and read data, both registered.
REQ-012 m_cyc_o, m_stb_o  out  NSLV: per-slave one-hot cycle and strobe.
REQ-013 m_we_o  out  1; m_sel_o  out  4; m_adr_o  out  32; m_dat_o  out  32: shared, latched request fields.
REQ-014 m_ack_i  in  NSLV; m_dat_i  in  NSLV*32: per-slave acknowledge and read data; slave k uses bits [32k+31:32k].
REQ-015 to_irq_o  out  1: single-cycle pulse on each timeout.
REQ-016 err_cnt_o  out  8: saturating count of misses plus timeouts.

Function
REQ-017 FSM states: IDLE, FWD, RESP.
REQ-018 IDLE: wbs_cyc_i&wbs_stb_i -> latch we/sel/adr/dat, then decode.
REQ-019 Decode: hit when adr[31:WIN_BITS+clog2(NSLV)] == BASE at the same bits; index = adr[WIN_BITS+clog2(NSLV)-1:WIN_BITS]; index >= NSLV counts as a miss.
REQ-020 Hit -> FWD with m_cyc_o[idx]=m_stb_o[idx]=1 from the next cycle; all other bits stay 0.
REQ-021 Miss -> RESP directly; wbs_dat_o=ERR_DATA; err_cnt_o increments.
REQ-022 FWD: wait counter starts at 0 and increments each cycle; m_ack_i[idx]=1 -> capture m_dat_i slice into wbs_dat_o, clear m_cyc/m_stb on the next edge, go to RESP.
REQ-023 m_ack_i bits other than idx are ignored in all states.
REQ-024 Timeout: counter == TIMEOUT-1 without ack -> go to RESP; wbs_dat_o=ERR_DATA; to_irq_o=1 for one cycle; err_cnt_o increments.
REQ-025 When ack and timeout occur in the same cycle, the ack wins: slave data is returned and there is no irq and no count.
REQ-026 RESP: wbs_ack_o=1 for exactly one cycle, then return to IDLE; a new request is accepted from the IDLE cycle onward.
REQ-027 Writes return wbs_dat_o=0 on a hit; ERR_DATA still applies on a miss or timeout.
REQ-028 Abort: wbs_cyc_i=0 during FWD -> clear m_cyc/m_stb on the next edge and return to IDLE with no ack, no irq and no count.
REQ-029 Latency from the request-sampled cycle T: miss ack at T+1; hit with same-cycle slave ack at T+2; timeout ack at T+TIMEOUT+1.
REQ-030 err_cnt_o saturates at 255 and does not wrap.
REQ-031 wbs_dat_o holds its value outside RESP.

Reset
REQ-032 wb_rst_i=1 at any edge: state=IDLE; wbs_ack_o=0, wbs_dat_o=0, m_cyc_o=m_stb_o=0, m_we_o=0, m_sel_o=0, m_adr_o=0, m_dat_o=0, to_irq_o=0, err_cnt_o=0, counter=0.
REQ-033 Reset during FWD drops the downstream cycle on the same edge; no ack is issued afterwards for that transaction.

Verification
REQ-034 Read 0x3001_0010, slave 1 acks after 3 cycles with 0x1234_5678 -> m_stb_o=4'b0010, wbs_dat_o=0x1234_5678, wbs_ack_o at T+5.
REQ-035 Read 0x3100_0000 -> wbs_ack_o at T+1 with 0xDEAD_BEEF; err_cnt_o goes 0->1; m_stb_o remains 0.
REQ-036 TIMEOUT=8, slave 2 silent -> ack at T+9 with 0xDEAD_BEEF, one to_irq_o pulse, m_stb_o cleared.
REQ-037 Slave ack in the same cycle as the timeout -> slave data returned, to_irq_o=0, err_cnt_o unchanged.
REQ-038 wbs_cyc_i dropped in the 2nd FWD cycle -> m_cyc_o=0 on the next edge, no wbs_ack_o; a following write to 0x3000_0004 completes normally.
REQ-039 wb_rst_i pulsed in FWD -> all outputs 0; 300 misses -> err_cnt_o=255.
